// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: IF/OF pipeline latch with stall/flush, 16x32 register file
// with write-back port and same-cycle bypass, immediate and branch-target generation.
module operand_fetch_stage #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] SP_INIT  = 32'h0000_0FFC,
  parameter logic [31:0] NOP_INST = 32'h6800_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        of_valid,
  output logic [31:0] of_pc,
  output logic [31:0] of_inst,
  output logic [4:0]  opcode,
  output logic        is_imm,
  output logic [3:0]  rd_addr,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] immx,
  output logic [31:0] branch_target
);

  typedef enum logic [4:0] {
    OP_ST   = 5'b01111,
    OP_CALL = 5'b10011,
    OP_RET  = 5'b10100
  } opcode_e;

  localparam int unsigned SP_IDX = 14;
  localparam logic [3:0]  RA_IDX = 4'd15;

  // IF/OF latch
  logic        valid_q, valid_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] inst_q,  inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = if_pc;
      inst_d  = NOP_INST;
    end else if (!stall) begin
      valid_d = if_valid;
      pc_d    = if_pc;
      inst_d  = if_valid ? if_inst : NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Register file; writes are independent of stall/flush
  logic [31:0] rf_q [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wb_en) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Decode
  logic [3:0] rd_fld, rs1_fld, rs2_fld;
  logic [3:0] addr_a, addr_b;

  always_comb begin
    rd_fld  = inst_q[25:22];
    rs1_fld = inst_q[21:18];
    rs2_fld = inst_q[17:14];
    addr_a  = (inst_q[31:27] == OP_RET)  ? RA_IDX : rs1_fld;
    addr_b  = (inst_q[31:27] == OP_ST)   ? rd_fld : rs2_fld;
    rd_addr = (inst_q[31:27] == OP_CALL) ? RA_IDX : rd_fld;
  end

  // Write-through bypass lets a same-cycle write-back be seen by either port
  always_comb begin
    op1 = (wb_en && (wb_rd == addr_a)) ? wb_data : rf_q[addr_a];
    op2 = (wb_en && (wb_rd == addr_b)) ? wb_data : rf_q[addr_b];
  end

  always_comb begin
    of_valid      = valid_q;
    of_pc         = pc_q;
    of_inst       = inst_q;
    opcode        = inst_q[31:27];
    is_imm        = inst_q[26];
    immx          = {{14{inst_q[17]}}, inst_q[17:0]};
    branch_target = pc_q + {{3{inst_q[26]}}, inst_q[26:0], 2'b00};
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: vector table through a scoreboard queue plus
// hand sequences for reset, stall/flush, bypass and call/ret.
module tb_operand_fetch_stage;

  localparam logic [31:0] NOP = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_inst, if_pc, wb_data;
  logic        if_valid, stall, flush, wb_en;
  logic [3:0]  wb_rd;
  logic        of_valid, is_imm;
  logic [31:0] of_pc, of_inst, op1, op2, immx, branch_target;
  logic [4:0]  opcode;
  logic [3:0]  rd_addr;

  int total = 0;
  int bad   = 0;

  operand_fetch_stage #(
    .NUM_REGS(16),
    .SP_INIT (32'h0000_0FFC),
    .NOP_INST(32'h6800_0000)
  ) dut (
    .clk(clk), .reset(reset),
    .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid),
    .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .of_valid(of_valid), .of_pc(of_pc), .of_inst(of_inst),
    .opcode(opcode), .is_imm(is_imm), .rd_addr(rd_addr),
    .op1(op1), .op2(op2), .immx(immx), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [3:0]  exp_rd;
    logic [31:0] exp_op1;
    logic [31:0] exp_op2;
    logic [31:0] exp_immx;
    logic [31:0] exp_bt;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    if_inst = inst; if_pc = pc; if_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    vec_t e;
    // inst, pc, valid, exp_valid, exp_inst, exp_rd, exp_op1, exp_op2, exp_immx, exp_bt
    vecs[0] = '{32'h0048_C000, 32'h10,  1'b1, 1'b1, 32'h0048_C000, 4'd1,  32'h5,  32'h7,  32'h0000_C000, 32'h0123_0010};
    vecs[1] = '{32'h7914_0000, 32'h30,  1'b1, 1'b1, 32'h7914_0000, 4'd4,  32'h55, 32'h44, 32'h0,         32'h0450_0030};
    vecs[2] = '{32'h9880_0000, 32'h40,  1'b1, 1'b1, 32'h9880_0000, 4'd15, 32'h0,  32'h0,  32'h0,         32'h0200_0040};
    vecs[3] = '{32'hA00C_8000, 32'h50,  1'b1, 1'b1, 32'hA00C_8000, 4'd0,  32'h40, 32'h5,  32'h0000_8000, 32'h0032_0050};
    vecs[4] = '{32'h4000_0003, 32'h100, 1'b1, 1'b1, 32'h4000_0003, 4'd0,  32'h0,  32'h0,  32'h3,         32'h0000_010C};
    vecs[5] = '{32'h47FF_FFFF, 32'h0,   1'b1, 1'b1, 32'h47FF_FFFF, 4'd15, 32'h40, 32'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[6] = '{32'h0002_0000, 32'h200, 1'b1, 1'b1, 32'h0002_0000, 4'd0,  32'h0,  32'h0,  32'hFFFE_0000, 32'h0008_0200};
    vecs[7] = '{32'h1234_5678, 32'h300, 1'b0, 1'b0, NOP,           4'd0,  32'h0,  32'h0,  32'h0,         32'h0000_0300};

    // Reset with clock idle
    reset = 1'b1; if_inst = '0; if_pc = '0; if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    chk("rst_valid",  32'(of_valid), 32'h0);
    chk("rst_pc",     of_pc, 32'h0);
    chk("rst_inst",   of_inst, NOP);
    chk("rst_opcode", 32'(opcode), 32'h0D);
    chk("rst_immx",   immx, 32'h0);
    // write-back during reset must be discarded
    wb_en = 1'b1; wb_rd = 4'd14; wb_data = 32'h1234_5678;
    tick();
    @(negedge clk);
    wb_en = 1'b0; reset = 1'b0;
    load(32'h0038_0000, 32'h4);
    chk("sp_init_op1", op1, 32'h0000_0FFC);

    // Preload register file
    wr(4'd2, 32'h5); wr(4'd3, 32'h7); wr(4'd4, 32'h44); wr(4'd5, 32'h55); wr(4'd15, 32'h40);

    // Vector table via scoreboard
    for (int i = 0; i < 8; i++) begin
      if_inst = vecs[i].inst; if_pc = vecs[i].pc; if_valid = vecs[i].valid;
      stall = 1'b0; flush = 1'b0;
      sb.push_back(vecs[i]);
      tick();
      if (sb.size() == 0) begin
        chk("sb_empty", 32'h0, 32'h1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_valid", i),  32'(of_valid), 32'(e.exp_valid));
        chk($sformatf("v%0d_pc", i),     of_pc, e.pc);
        chk($sformatf("v%0d_inst", i),   of_inst, e.exp_inst);
        chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(e.exp_inst[31:27]));
        chk($sformatf("v%0d_isimm", i),  32'(is_imm), 32'(e.exp_inst[26]));
        chk($sformatf("v%0d_rd", i),     32'(rd_addr), 32'(e.exp_rd));
        chk($sformatf("v%0d_op1", i),    op1, e.exp_op1);
        chk($sformatf("v%0d_op2", i),    op2, e.exp_op2);
        chk($sformatf("v%0d_immx", i),   immx, e.exp_immx);
        chk($sformatf("v%0d_bt", i),     branch_target, e.exp_bt);
      end
    end
    if_valid = 1'b0;

    // Stall then stall+flush
    load(32'h0048_C000, 32'h20);
    chk("ld_pc", of_pc, 32'h20);
    if_inst = 32'h0000_0000; if_pc = 32'h24; if_valid = 1'b1; stall = 1'b1;
    tick();
    chk("stall_pc",    of_pc, 32'h20);
    chk("stall_valid", 32'(of_valid), 32'h1);
    chk("stall_inst",  of_inst, 32'h0048_C000);
    if_pc = 32'h28; flush = 1'b1;
    tick();
    chk("flush_valid", 32'(of_valid), 32'h0);
    chk("flush_inst",  of_inst, NOP);
    chk("flush_pc",    of_pc, 32'h28);
    stall = 1'b0; flush = 1'b0; if_valid = 1'b0;

    // Bypass on port B for a store, port A left alone
    load(32'h7914_0000, 32'h60);
    chk("st_op2_pre", op2, 32'h44);
    stall = 1'b1;
    wb_en = 1'b1; wb_rd = 4'd4; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("byp_op2", op2, 32'hDEAD_BEEF);
    chk("byp_op1", op1, 32'h55);
    tick();
    wb_en = 1'b0;
    #1;
    chk("wr_op2", op2, 32'hDEAD_BEEF);
    wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'h0BAD_F00D;
    #1;
    chk("byp_op1_a", op1, 32'h0BAD_F00D);
    wb_en = 1'b0; stall = 1'b0;

    // Call, then reset, then ret sees cleared r15
    load(32'h9880_0000, 32'h70);
    chk("call_rd", 32'(rd_addr), 32'd15);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(of_valid), 32'h0);
    chk("mid_rst_inst",  of_inst, NOP);
    @(negedge clk);
    reset = 1'b0;
    load(32'hA00C_8000, 32'h80);
    chk("ret_op1_after_rst", op1, 32'h0);
    chk("ret_rd", 32'(rd_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
